// File: rtl/mouse_master_sm.sv
// PS/2 host sequencer: resets/enables the mouse, then assembles 3-byte packets into status/dX/dY.
// Optional macro MOUSE_SAMPLE_RATE_EN adds the F3 <rate> step to the init sequence.
module mouse_master_sm #(
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter logic [7:0]  SAMPLE_RATE    = 8'h64
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   input  logic       BYTE_READY,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic       INIT_DONE,
   output logic [3:0] MASTER_STATE_CODE
);

   typedef enum logic [3:0] {
      START          = 4'd0,
      SEND_FF        = 4'd1,
      WAIT_SENT_FF   = 4'd2,
      WAIT_ACK_FF    = 4'd3,
      WAIT_BAT       = 4'd4,
      WAIT_ID        = 4'd5,
      SEND_F3        = 4'd6,
      WAIT_SENT_F3   = 4'd7,
      WAIT_ACK_F3    = 4'd8,
      SEND_RATE      = 4'd9,
      WAIT_SENT_RATE = 4'd10,
      WAIT_ACK_RATE  = 4'd11,
      SEND_F4        = 4'd12,
      WAIT_SENT_F4   = 4'd13,
      WAIT_ACK_F4    = 4'd14,
      STREAM         = 4'd15
   } state_t;

   localparam logic [26:0] CNT_LAST = 27'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      nxt;
   logic [26:0] cnt;
   logic [1:0]  idx;
   logic [7:0]  sh0;
   logic [7:0]  sh1;
   logic        timed_out;
   logic        rx_ok;

   assign timed_out = (cnt == CNT_LAST);
   assign rx_ok     = (BYTE_ERROR_CODE == 2'b00);

   // A received byte takes priority over a timeout expiring in the same cycle.
   function automatic state_t on_resp(input state_t cur, input logic [7:0] want, input state_t pass);
      if (BYTE_READY) return (rx_ok && BYTE_READ == want) ? pass : START;
      if (timed_out)  return START;
      return cur;
   endfunction

   function automatic state_t on_sent(input state_t cur, input state_t pass);
      if (BYTE_SENT) return pass;
      if (timed_out) return START;
      return cur;
   endfunction

   always_comb begin
      nxt = START;
      case (state)
         START:          nxt = SEND_FF;
         SEND_FF:        nxt = WAIT_SENT_FF;
         WAIT_SENT_FF:   nxt = on_sent(state, WAIT_ACK_FF);
         WAIT_ACK_FF:    nxt = on_resp(state, 8'hFA, WAIT_BAT);
         WAIT_BAT:       nxt = on_resp(state, 8'hAA, WAIT_ID);
`ifdef MOUSE_SAMPLE_RATE_EN
         WAIT_ID:        nxt = on_resp(state, 8'h00, SEND_F3);
         SEND_F3:        nxt = WAIT_SENT_F3;
         WAIT_SENT_F3:   nxt = on_sent(state, WAIT_ACK_F3);
         WAIT_ACK_F3:    nxt = on_resp(state, 8'hFA, SEND_RATE);
         SEND_RATE:      nxt = WAIT_SENT_RATE;
         WAIT_SENT_RATE: nxt = on_sent(state, WAIT_ACK_RATE);
         WAIT_ACK_RATE:  nxt = on_resp(state, 8'hFA, SEND_F4);
`else
         WAIT_ID:        nxt = on_resp(state, 8'h00, SEND_F4);
`endif
         SEND_F4:        nxt = WAIT_SENT_F4;
         WAIT_SENT_F4:   nxt = on_sent(state, WAIT_ACK_F4);
         WAIT_ACK_F4:    nxt = on_resp(state, 8'hFA, STREAM);
         STREAM:         nxt = STREAM;
         default:        nxt = START;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state             <= START;
         cnt               <= '0;
         idx               <= '0;
         sh0               <= '0;
         sh1               <= '0;
         SEND_BYTE         <= 1'b0;
         BYTE_TO_SEND      <= '0;
         MOUSE_STATUS      <= '0;
         MOUSE_DX          <= '0;
         MOUSE_DY          <= '0;
         SEND_INTERRUPT    <= 1'b0;
         INIT_DONE         <= 1'b0;
         MASTER_STATE_CODE <= '0;
      end else begin
         state             <= nxt;
         MASTER_STATE_CODE <= nxt;
         INIT_DONE         <= (nxt == STREAM);
         SEND_BYTE         <= 1'b0;
         SEND_INTERRUPT    <= 1'b0;
         if (state == STREAM) begin
            // Gap timer runs only while a packet is partially assembled.
            if (BYTE_READY) begin
               cnt <= '0;
               if (!rx_ok) begin
                  idx <= '0;
               end else begin
                  case (idx)
                     2'd0: if (BYTE_READ[3]) begin sh0 <= BYTE_READ; idx <= 2'd1; end
                     2'd1: begin sh1 <= BYTE_READ; idx <= 2'd2; end
                     2'd2: begin
                        MOUSE_STATUS   <= sh0;
                        MOUSE_DX       <= sh1;
                        MOUSE_DY       <= BYTE_READ;
                        SEND_INTERRUPT <= 1'b1;
                        idx            <= 2'd0;
                     end
                     default: idx <= 2'd0;
                  endcase
               end
            end else if (idx == 2'd0) begin
               cnt <= '0;
            end else if (timed_out) begin
               cnt <= '0;
               idx <= '0;
            end else begin
               cnt <= cnt + 27'd1;
            end
         end else if (nxt != state) begin
            cnt <= '0;
            idx <= '0;
            case (nxt)
               SEND_FF:   begin SEND_BYTE <= 1'b1; BYTE_TO_SEND <= 8'hFF;       end
               SEND_F3:   begin SEND_BYTE <= 1'b1; BYTE_TO_SEND <= 8'hF3;       end
               SEND_RATE: begin SEND_BYTE <= 1'b1; BYTE_TO_SEND <= SAMPLE_RATE; end
               SEND_F4:   begin SEND_BYTE <= 1'b1; BYTE_TO_SEND <= 8'hF4;       end
               default:   ;
            endcase
         end else begin
            cnt <= cnt + 27'd1;
         end
      end
   end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Bench for mouse_master_sm: scripted PS/2 device responses plus a queue-based packet model.
module tb_mouse_master_sm;

   localparam int TO = 1000;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT = 1'b0;
   logic       BYTE_READY = 1'b0;
   logic [7:0] BYTE_READ = 8'h00;
   logic [1:0] BYTE_ERROR_CODE = 2'b00;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic       INIT_DONE;
   logic [3:0] MASTER_STATE_CODE;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_s = 8'h00;
   logic [7:0] exp_x = 8'h00;
   logic [7:0] exp_y = 8'h00;
   logic [7:0] pend[$];

   mouse_master_sm #(.TIMEOUT_CYCLES(TO), .SAMPLE_RATE(8'h64)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .SEND_BYTE(SEND_BYTE),
      .BYTE_TO_SEND(BYTE_TO_SEND),
      .BYTE_SENT(BYTE_SENT),
      .BYTE_READY(BYTE_READY),
      .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
      .MOUSE_STATUS(MOUSE_STATUS),
      .MOUSE_DX(MOUSE_DX),
      .MOUSE_DY(MOUSE_DY),
      .SEND_INTERRUPT(SEND_INTERRUPT),
      .INIT_DONE(INIT_DONE),
      .MASTER_STATE_CODE(MASTER_STATE_CODE)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_send"}, SEND_BYTE, 0);
      chk({tag, "_tx"},   BYTE_TO_SEND, 0);
      chk({tag, "_stat"}, MOUSE_STATUS, 0);
      chk({tag, "_dx"},   MOUSE_DX, 0);
      chk({tag, "_dy"},   MOUSE_DY, 0);
      chk({tag, "_irq"},  SEND_INTERRUPT, 0);
      chk({tag, "_done"}, INIT_DONE, 0);
      chk({tag, "_st"},   MASTER_STATE_CODE, 0);
   endtask

   // Packet rules: sync bit gates the first byte, any error drops the partial packet.
   task automatic model_rx(input logic [7:0] b, input logic [1:0] err, output bit irq);
      irq = 1'b0;
      if (err != 2'b00) begin
         pend.delete();
      end else if (pend.size() != 0 || b[3]) begin
         pend.push_back(b);
         if (pend.size() == 3) begin
            exp_s = pend[0];
            exp_x = pend[1];
            exp_y = pend[2];
            pend.delete();
            irq = 1'b1;
         end
      end
   endtask

   task automatic rx(input logic [7:0] b, input logic [1:0] err, input string tag);
      bit irq;
      model_rx(b, err, irq);
      BYTE_READ = b;
      BYTE_ERROR_CODE = err;
      BYTE_READY = 1'b1;
      tick();
      BYTE_READY = 1'b0;
      BYTE_ERROR_CODE = 2'b00;
      chk({tag, "_irq"},  SEND_INTERRUPT, irq);
      chk({tag, "_stat"}, MOUSE_STATUS, exp_s);
      chk({tag, "_dx"},   MOUSE_DX, exp_x);
      chk({tag, "_dy"},   MOUSE_DY, exp_y);
   endtask

   task automatic resp(input logic [7:0] b, input logic [1:0] err);
      BYTE_READ = b;
      BYTE_ERROR_CODE = err;
      BYTE_READY = 1'b1;
      tick();
      BYTE_READY = 1'b0;
      BYTE_ERROR_CODE = 2'b00;
   endtask

   task automatic pulse_sent();
      BYTE_SENT = 1'b1;
      tick();
      BYTE_SENT = 1'b0;
   endtask

   task automatic wait_send(input logic [7:0] exp, input string tag);
      int n;
      n = 0;
      while (SEND_BYTE !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_seen"}, SEND_BYTE, 1);
      chk({tag, "_byte"}, BYTE_TO_SEND, exp);
      tick();
      chk({tag, "_one"}, SEND_BYTE, 0);
   endtask

   task automatic do_init();
      logic [7:0] cmds[$];
`ifdef MOUSE_SAMPLE_RATE_EN
      cmds = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
`else
      cmds = '{8'hFF, 8'hF4};
`endif
      foreach (cmds[k]) begin
         wait_send(cmds[k], "init_send");
         tick(int'($urandom_range(0, 3)));
         pulse_sent();
         resp(8'hFA, 2'b00);
         if (cmds[k] == 8'hFF) begin
            resp(8'hAA, 2'b00);
            resp(8'h00, 2'b00);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0;
      tick(2);
      chk_zero("reset");
      RESET = 1'b1;

      do_init();
      chk("init_done", INIT_DONE, 1);
      chk("init_state", MASTER_STATE_CODE, 15);

      // Directed packets: clean, misaligned lead byte, error mid-packet.
      pend.delete();
      rx(8'h08, 2'b00, "pa0");
      rx(8'h05, 2'b00, "pa1");
      rx(8'hFB, 2'b00, "pa2");
      tick();
      chk("pa_irq_one", SEND_INTERRUPT, 0);
      rx(8'h00, 2'b00, "mis0");
      rx(8'h18, 2'b00, "mis1");
      rx(8'h01, 2'b00, "mis2");
      rx(8'h02, 2'b00, "mis3");
      rx(8'h09, 2'b00, "er0");
      rx(8'h33, 2'b01, "er1");
      rx(8'h09, 2'b00, "er2");
      rx(8'h01, 2'b00, "er3");
      rx(8'h02, 2'b00, "er4");

      for (int i = 0; i < 80; i++) begin
         logic [7:0] b;
         logic [1:0] e;
         int gap;
         b = 8'($urandom);
         e = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rx(b, e, "rand");
         gap = int'($urandom_range(0, 3));
         repeat (gap) begin
            tick();
            chk("rand_gap_irq", SEND_INTERRUPT, 0);
         end
      end

      // Packet-gap timeout drops a partial packet but stays streaming.
      rx(8'h00, 2'b01, "gap_clr");
      rx(8'h08, 2'b00, "gap0");
      tick(TO + 5);
      pend.delete();
      chk("gap_state", MASTER_STATE_CODE, 15);
      rx(8'h11, 2'b00, "gap1");
      rx(8'h22, 2'b00, "gap2");
      rx(8'h44, 2'b00, "gap3");

      // Reset right after the first byte of a packet.
      rx(8'h09, 2'b00, "rst0");
      RESET = 1'b0;
      tick();
      chk_zero("rst_mid");
      RESET = 1'b1;
      exp_s = 8'h00;
      exp_x = 8'h00;
      exp_y = 8'h00;
      pend.delete();
      wait_send(8'hFF, "rst_ff");

      // Bad BAT code forces a restart.
      pulse_sent();
      chk("bat_wait_ack", MASTER_STATE_CODE, 3);
      resp(8'hFA, 2'b00);
      chk("bat_wait_bat", MASTER_STATE_CODE, 4);
      resp(8'hFC, 2'b00);
      chk("bat_restart", MASTER_STATE_CODE, 0);
      wait_send(8'hFF, "bat_ff");

      // Missing ACK: restart exactly TO cycles after entering WAIT_ACK.
      pulse_sent();
      chk("to_wait_ack", MASTER_STATE_CODE, 3);
      tick(TO - 1);
      chk("to_before", MASTER_STATE_CODE, 3);
      tick();
      chk("to_expired", MASTER_STATE_CODE, 0);
      wait_send(8'hFF, "to_ff");

      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      do_init();
      chk("reinit_done", INIT_DONE, 1);
      chk("reinit_state", MASTER_STATE_CODE, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
